// File: rtl/stream_grant_arbiter.sv
// stream_grant_arbiter
//   One arbiter per output port of a stream switch or multiplexer. It picks
//   which input stream owns the output. Grant, grant-valid and the encoded
//   index are all registered, so a request shows up as a grant one clock
//   after it is sampled.
//
//   Selection is fixed priority or round-robin. Optionally, the current grant
//   can be held until the owner releases it, either by acknowledge or by
//   dropping its request.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   request        per-port request
//   acknowledge    per-port release; only the bit of the granted port counts
//   grant          registered one-hot grant, all zero when idle
//   grant_valid    registered, high when any grant bit is set
//   grant_encoded  registered binary index of the granted port
module stream_grant_arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  logic [PORTS-1:0] mask_q;
  logic [PORTS-1:0] mask_d;
  logic [PORTS-1:0] grant_d;
  logic             valid_d;
  logic [IDX_W-1:0] enc_d;

  logic [PORTS-1:0] req_masked;
  logic [IDX_W-1:0] idx_req;
  logic [IDX_W-1:0] idx_masked;
  logic [IDX_W-1:0] sel;
  logic             hold;

  // Index of the winning bit of v. The loop order makes the highest-priority
  // bit the last one assigned.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  assign req_masked = request & mask_q;
  assign idx_req    = prio_idx(request);
  assign idx_masked = prio_idx(req_masked);

  always_comb begin
    grant_d = grant;
    valid_d = grant_valid;
    enc_d   = grant_encoded;
    mask_d  = mask_q;
    sel     = idx_req;
    hold    = 1'b0;

    if ((ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) && ((grant & request) != '0)) begin
      hold = 1'b1;
    end else if ((ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && grant_valid &&
                 ((grant & acknowledge) == '0)) begin
      hold = 1'b1;
    end

    if (!hold) begin
      if (request != '0) begin
        // An empty masked set covers both a fresh mask after reset and a
        // rotation that has wrapped past the last requestor.
        if ((ARB_TYPE_ROUND_ROBIN != 0) && (req_masked != '0)) begin
          sel = idx_masked;
        end
        grant_d = PORTS'(1) << sel;
        valid_d = 1'b1;
        enc_d   = sel;
        if (ARB_TYPE_ROUND_ROBIN != 0) begin
          // Keep only the ports that rank below the one just granted.
          if (ARB_LSB_HIGH_PRIORITY != 0) begin
            mask_d = {PORTS{1'b1}} << (int'(sel) + 1);
          end else begin
            mask_d = {PORTS{1'b1}} >> (PORTS - int'(sel));
          end
        end
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask_q        <= '0;
    end else begin
      grant         <= grant_d;
      grant_valid   <= valid_d;
      grant_encoded <= enc_d;
      mask_q        <= mask_d;
    end
  end

endmodule

// File: tb/tb_stream_grant_arbiter.sv
// Bench for stream_grant_arbiter: eight configurations run side by side on
// the same request/acknowledge stimulus, each tracked by its own reference
// model.
module tb_stream_grant_arbiter;

  // Per-configuration settings, bit k belongs to instance k.
  //  k: 0 fixed lsb        1 rr lsb            2 rr lsb block-ack
  //     3 fixed lsb block  4 fixed msb         5 rr msb block-ack
  //     6 single port      7 rr msb block (no ack)
  localparam logic [7:0] P_RR  = 8'b1010_0110;
  localparam logic [7:0] P_BLK = 8'b1010_1100;
  localparam logic [7:0] P_ACK = 8'b0010_0100;
  localparam logic [7:0] P_LSB = 8'b0100_1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] acknowledge = '0;

  wire [3:0] g [8];
  wire       v [8];
  wire [1:0] e [8];

  int checks = 0;
  int errors = 0;

  int mg    [8];
  int mlast [8];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 8; k++) begin : g_dut
    if (k == 6) begin : g_p1
      logic [0:0] gg;
      logic [0:0] ee;
      logic       vv;
      stream_grant_arbiter #(
        .PORTS(1), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
        .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1)
      ) u_dut (
        .clk(clk), .rst(rst),
        .request(request[0:0]), .acknowledge(acknowledge[0:0]),
        .grant(gg), .grant_valid(vv), .grant_encoded(ee)
      );
      assign g[k] = {3'b000, gg};
      assign v[k] = vv;
      assign e[k] = {1'b0, ee};
    end else begin : g_p4
      stream_grant_arbiter #(
        .PORTS(4),
        .ARB_TYPE_ROUND_ROBIN(P_RR[k] ? 1 : 0),
        .ARB_BLOCK(P_BLK[k] ? 1 : 0),
        .ARB_BLOCK_ACK(P_ACK[k] ? 1 : 0),
        .ARB_LSB_HIGH_PRIORITY(P_LSB[k] ? 1 : 0)
      ) u_dut (
        .clk(clk), .rst(rst),
        .request(request), .acknowledge(acknowledge),
        .grant(g[k]), .grant_valid(v[k]), .grant_encoded(e[k])
      );
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nports(input int k);
    return (k == 6) ? 1 : 4;
  endfunction

  // Model state: mg = granted port or -1, mlast = last port granted by
  // round-robin (-1 / PORTS means "nothing yet", i.e. start from the top).
  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mg[k]    = -1;
      mlast[k] = P_LSB[k] ? -1 : nports(k);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] a);
    for (int k = 0; k < 8; k++) begin
      int         n;
      int         cur;
      int         pick;
      bit         held;
      logic [3:0] rq;
      n    = nports(k);
      cur  = mg[k];
      pick = -1;
      held = 0;
      rq   = (k == 6) ? (r & 4'b0001) : r;
      if (P_BLK[k] && cur >= 0) begin
        if (!P_ACK[k] && rq[cur]) held = 1;
        if (P_ACK[k] && !a[cur]) held = 1;
      end
      if (!held) begin
        if (rq == 4'b0000) begin
          mg[k] = -1;
        end else begin
          if (P_LSB[k]) begin
            // Round-robin: next requestor above the previous winner, else wrap.
            if (P_RR[k])
              for (int i = 0; i < n; i++)
                if (pick < 0 && rq[i] && i > mlast[k]) pick = i;
            for (int i = 0; i < n; i++)
              if (pick < 0 && rq[i]) pick = i;
          end else begin
            if (P_RR[k])
              for (int i = n - 1; i >= 0; i--)
                if (pick < 0 && rq[i] && i < mlast[k]) pick = i;
            for (int i = n - 1; i >= 0; i--)
              if (pick < 0 && rq[i]) pick = i;
          end
          mg[k]    = pick;
          mlast[k] = pick;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 8; k++) begin
      logic [3:0] eg;
      logic       ev;
      logic [1:0] ee;
      eg = (mg[k] < 0) ? 4'b0000 : 4'(1 << mg[k]);
      ev = (mg[k] >= 0);
      ee = (mg[k] < 0) ? 2'd0 : 2'(mg[k]);
      chk($sformatf("model cfg%0d {grant,valid,enc}", k), {25'd0, g[k], v[k], e[k]},
          {25'd0, eg, ev, ee});
    end
  endtask

  always begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step(request, acknowledge);
    #1;
    compare_all();
  end

  task automatic step(input logic [3:0] r, input logic [3:0] a);
    @(negedge clk);
    request     = r;
    acknowledge = a;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq1 [5];
    int seq2 [3];
    seq1 = '{0, 1, 2, 3, 0};
    seq2 = '{2, 0, 2};

    repeat (3) @(negedge clk);
    chk("reset grant", {28'd0, g[0]}, 32'd0);
    chk("reset valid", {31'd0, v[0]}, 32'd0);
    rst = 1'b0;

    // Fixed priority, both priority directions
    step(4'b1010, 4'b0000);
    chk("fp lsb grant", {28'd0, g[0]}, 32'h2);
    chk("fp lsb enc", {30'd0, e[0]}, 32'd1);
    chk("fp lsb valid", {31'd0, v[0]}, 32'd1);
    chk("fp msb grant", {28'd0, g[4]}, 32'h8);
    chk("fp msb enc", {30'd0, e[4]}, 32'd3);

    step(4'b0000, 4'b0000);
    chk("idle grant", {28'd0, g[0]}, 32'd0);
    chk("idle valid", {31'd0, v[0]}, 32'd0);
    chk("idle enc", {30'd0, e[0]}, 32'd0);

    step(4'b0001, 4'b0000);
    chk("single port grant", {28'd0, g[6]}, 32'd1);
    chk("single port enc", {30'd0, e[6]}, 32'd0);

    // Round-robin rotation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000);
      chk($sformatf("rr all seq[%0d]", i), {30'd0, e[1]}, 32'(seq1[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 4'b0000);
      chk($sformatf("rr 0101 seq[%0d]", i), {30'd0, e[1]}, 32'(seq2[i]));
    end

    // Block until acknowledge
    do_reset();
    step(4'b0011, 4'b0000);
    chk("ack first grant", {28'd0, g[2]}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000);
      chk($sformatf("ack held %0d", i), {28'd0, g[2]}, 32'h1);
    end
    step(4'b0000, 4'b0010);
    chk("ack other port ignored", {28'd0, g[2]}, 32'h1);
    step(4'b0010, 4'b0001);
    chk("ack release grant", {28'd0, g[2]}, 32'h2);
    chk("ack release enc", {30'd0, e[2]}, 32'd1);

    // Block while request held
    do_reset();
    step(4'b0100, 4'b0000);
    chk("blk first grant", {28'd0, g[3]}, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 4'b0000);
      chk($sformatf("blk held %0d", i), {28'd0, g[3]}, 32'h4);
    end
    step(4'b0001, 4'b0000);
    chk("blk release grant", {28'd0, g[3]}, 32'h1);

    // Asynchronous reset in the middle of a grant
    do_reset();
    step(4'b0100, 4'b0000);
    chk("pre-reset grant", {28'd0, g[1]}, 32'h4);
    #1 rst = 1'b1;
    #1;
    chk("async reset grant", {28'd0, g[1]}, 32'd0);
    chk("async reset valid", {31'd0, v[1]}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    request = 4'b1100;
    @(posedge clk);
    #2;
    chk("post-reset unmasked grant", {28'd0, g[1]}, 32'h4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 199) == 0);
      request     = 4'($urandom);
      acknowledge = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
    end
    @(negedge clk);
    rst = 1'b0;
    request = '0;
    acknowledge = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_grant_arbiter.md
Name: stream_grant_arbiter

Overview:
- Parameterised N-port arbiter for stream switches and multiplexers.
- One arbiter sits per output port; it selects which input stream owns that output.
- Produces a registered one-hot grant, a grant-valid flag and a binary-encoded grant index.
- Supports fixed-priority or round-robin selection, with optional grant blocking until release or until acknowledge.

Parameters:
- PORTS, 4, number of requestors (≥1).
- ARB_TYPE_ROUND_ROBIN, 0, 1 = round-robin, 0 = fixed priority.
- ARB_BLOCK, 0, 1 = hold the current grant (see Behaviour).
- ARB_BLOCK_ACK, 1, with ARB_BLOCK=1: 1 = hold the grant until acknowledge, 0 = hold while request stays asserted.
- ARB_LSB_HIGH_PRIORITY, 0, 1 = lowest index has highest priority, 0 = highest index has highest priority.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- request, input, PORTS, per-port request.
- acknowledge, input, PORTS, per-port release of the current grant.
- grant, output, PORTS, registered one-hot grant (all zero when none).
- grant_valid, output, 1, registered; high when any grant bit is set.
- grant_encoded, output, max(1,$clog2(PORTS)), registered index of the granted port.

Behaviour:
- Reset (async, rst=1): grant=0, grant_valid=0, grant_encoded=0, round-robin mask=0. Outputs stay there until rst is low and a clock edge occurs.
- Every output is a register. A decision computed from the inputs of cycle t appears after edge t+1, so the request→grant latency is 1 cycle.
- Priority encoder: picks the single winning bit of a vector, plus a valid flag.
  - ARB_LSB_HIGH_PRIORITY=1: the lowest set index wins.
  - ARB_LSB_HIGH_PRIORITY=0: the highest set index wins.
- Next-state rules, evaluated in order:
  1. ARB_BLOCK=1, ARB_BLOCK_ACK=0, and (grant & request)≠0: hold grant, grant_valid and grant_encoded.
  2. ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1, and (grant & acknowledge)=0: hold. Request is ignored while held.
  3. Otherwise, if any request is set, grant a new winner:
     - Fixed priority: the encoder result over request.
     - Round-robin: if (request & mask)≠0, the encoder result over (request & mask); otherwise the encoder result over request.
     - Round-robin mask update after granting index i: LSB-high mode uses all-ones shifted left by (i+1); MSB-high mode uses all-ones shifted right by (PORTS−i).
     - A mask of 0 after reset, or a mask that has wrapped, falls back to the unmasked encoder.
  4. Otherwise: grant=0, grant_valid=0, grant_encoded=0, mask unchanged.
- Acknowledge bits on ports that are not granted are ignored.
- Acknowledge and a new request in the same cycle: the grant is released and re-arbitrated in that same cycle, so the new winner appears on the next edge with no idle gap.
- ARB_BLOCK=0: re-arbitrate every cycle.
  - Fixed priority: the grant follows the request.
  - Round-robin: the grant rotates among the active requestors each cycle.
- PORTS=1: grant = request registered; grant_encoded is always 0.
- grant is always one-hot or zero. grant_encoded always matches grant when grant_valid=1.
- Reset asserted mid-grant: the grant clears immediately (async). The first post-reset arbitration is unmasked.

Test Plan:
- Fixed priority, PORTS=4, LSB-high, ARB_BLOCK=0: request=4'b1010 → next cycle grant=4'b0010, grant_encoded=1, grant_valid=1. With MSB-high: grant=4'b1000, grant_encoded=3.
- Round-robin, PORTS=4, LSB-high, ARB_BLOCK=0: request=4'b1111 held → grant_encoded sequence 0,1,2,3,0 on consecutive cycles. Then request=4'b0101 → sequence alternates 2,0,2.
- Block-ack, round-robin: request=4'b0011 for one cycle, then 0 → grant=4'b0001 held for 5 cycles with request=0. Pulse acknowledge=4'b0010 → grant unchanged. Pulse acknowledge=4'b0001 with request=4'b0010 → next cycle grant=4'b0010, grant_encoded=1.
- Block without ack (ARB_BLOCK_ACK=0): grant on port 2 persists while request[2]=1, even with higher-priority request[0]=1. When request[2] drops → next cycle grant=4'b0001.
- Idle: all requests 0 with no hold → grant=0, grant_valid=0, grant_encoded=0 one cycle later.
- Async reset mid-grant: assert rst between clock edges while grant=4'b0100 → outputs go to 0 without a clock edge. After release with request=4'b1100 (LSB-high round-robin) → grant=4'b0100.
